// File: rtl/instr_encoder_loader.sv
// Instruction encoder and loader.
// Packs instruction field bundles into 32-bit words, buffers them in a
// 4-entry FIFO and writes them to consecutive instruction-memory words
// starting at a word-aligned base address.
module instr_encoder_loader (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_finish,
   input  logic [31:0] i_base_addr,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [3:0]  i_cond,
   input  logic [1:0]  i_mode,
   input  logic        i_imm,
   input  logic [3:0]  i_opcode,
   input  logic        i_s_bit,
   input  logic [3:0]  i_rn,
   input  logic [3:0]  i_rd,
   input  logic [23:0] i_operand,
   output logic        o_mem_we,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_word_count,
   output logic [7:0]  o_err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } stateT;

   stateT       r_state;
   stateT       w_nextState;

   logic [31:0] r_fifoMem [4];
   logic [1:0]  r_wrPtr;
   logic [1:0]  r_rdPtr;
   logic [2:0]  r_fifoCount;

   logic [31:0] r_addr;
   logic [15:0] r_wordCount;
   logic [7:0]  r_errCount;

   logic        w_fifoFull;
   logic        w_fifoEmpty;
   logic        w_accept;
   logic        w_illegal;
   logic        w_push;
   logic        w_pop;
   logic        w_startSession;
   logic [31:0] w_encWord;

   assign w_fifoFull     = (r_fifoCount == 3'd4);
   assign w_fifoEmpty    = (r_fifoCount == 3'd0);
   assign w_illegal      = (i_mode == 2'b11);
   assign w_startSession = (r_state == IDLE) && i_start;

   assign o_in_ready   = (r_state == RUN) && !w_fifoFull;
   assign o_mem_we     = !w_fifoEmpty && ((r_state == RUN) || (r_state == DRAIN));
   assign o_mem_wdata  = r_fifoMem[r_rdPtr];
   assign o_mem_addr   = r_addr;
   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == DONE);
   assign o_word_count = r_wordCount;
   assign o_err_count  = r_errCount;

   assign w_accept = i_in_valid && o_in_ready;
   assign w_push   = w_accept && !w_illegal;
   assign w_pop    = o_mem_we && i_mem_ready;

   // Build the instruction word from the field bundle; memory ops reuse the
   // data-processing layout with the opcode pinned to address-add, branches
   // carry the full 24-bit offset, and illegal bundles produce no word.
   always_comb begin
      w_encWord = '0;
      case (i_mode)
         2'b00:   w_encWord = {i_cond, i_mode, i_imm, i_opcode, i_s_bit,
                               i_rn, i_rd, i_operand[11:0]};
         2'b01:   w_encWord = {i_cond, i_mode, i_imm, 4'b0100, i_s_bit,
                               i_rn, i_rd, i_operand[11:0]};
         2'b10:   w_encWord = {i_cond, 4'b1010, i_operand};
         default: w_encWord = '0;
      endcase
   end

   // Session state register; reset always lands in IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Session sequencing: start only matters in IDLE, finish only in RUN,
   // DRAIN waits for the FIFO to empty and DONE lasts exactly one cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (i_start) w_nextState = RUN;
         RUN:     if (i_finish) w_nextState = DRAIN;
         DRAIN:   if (w_fifoEmpty) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // FIFO storage; cleared on reset so the write-data output reads zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_fifoMem[i] <= '0;
         end
      end else if (w_push) begin
         r_fifoMem[r_wrPtr] <= w_encWord;
      end
   end

   // FIFO pointers and occupancy; a push and pop on the same edge cancel in
   // the count, and the 2-bit pointers wrap naturally at four entries.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_fifoCount <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 2'd1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_fifoCount <= r_fifoCount + 3'd1;
            2'b01:   r_fifoCount <= r_fifoCount - 3'd1;
            default: r_fifoCount <= r_fifoCount;
         endcase
      end
   end

   // Write address: loaded word-aligned when a session opens, then stepped
   // by one word for every completed memory write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr <= '0;
      end else if (w_startSession) begin
         r_addr <= i_base_addr & ~32'h3;
      end else if (w_pop) begin
         r_addr <= r_addr + 32'd4;
      end
   end

   // Per-session statistics: cleared when a session opens, otherwise held
   // (including across IDLE) so software can read the last session's totals.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wordCount <= '0;
         r_errCount  <= '0;
      end else if (w_startSession) begin
         r_wordCount <= '0;
         r_errCount  <= '0;
      end else begin
         if (w_pop) begin
            r_wordCount <= r_wordCount + 16'd1;
         end
         if (w_accept && w_illegal && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed bundles push their
// hand-computed words into a queue, a monitor checks every memory write.
module tb_instr_encoder_loader;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic        i_finish;
   logic [31:0] i_base_addr;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [3:0]  i_cond;
   logic [1:0]  i_mode;
   logic        i_imm;
   logic [3:0]  i_opcode;
   logic        i_s_bit;
   logic [3:0]  i_rn;
   logic [3:0]  i_rd;
   logic [23:0] i_operand;
   logic        o_mem_we;
   logic        i_mem_ready;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_word_count;
   logic [7:0]  o_err_count;

   int          vecCount  = 0;
   int          missCount = 0;
   logic [63:0] expQ [$];
   logic [31:0] expAddr   = '0;

   instr_encoder_loader dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_finish     (i_finish),
      .i_base_addr  (i_base_addr),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_cond       (i_cond),
      .i_mode       (i_mode),
      .i_imm        (i_imm),
      .i_opcode     (i_opcode),
      .i_s_bit      (i_s_bit),
      .i_rn         (i_rn),
      .i_rd         (i_rd),
      .i_operand    (i_operand),
      .o_mem_we     (o_mem_we),
      .i_mem_ready  (i_mem_ready),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_word_count (o_word_count),
      .o_err_count  (o_err_count)
   );

   // Free-running 10-unit clock.
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: every completed memory write must match the oldest queued
   // word and its address.
   always @(negedge i_clk) begin
      if (i_rst_n && o_mem_we && i_mem_ready) begin
         if (expQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     o_mem_addr, o_mem_wdata);
         end else begin
            logic [63:0] exp;
            exp = expQ.pop_front();
            checkOutput("write_addr", {32'h0, o_mem_addr}, {32'h0, exp[63:32]});
            checkOutput("write_data", {32'h0, o_mem_wdata}, {32'h0, exp[31:0]});
         end
      end
   end

   // Drive one bundle and hold it until the handshake fires; the expected
   // word is queued only for legal modes.
   task automatic applyStimulus(input logic [3:0] c, input logic [1:0] m,
                                input logic im, input logic [3:0] op,
                                input logic s, input logic [3:0] rn,
                                input logic [3:0] rd, input logic [23:0] operand,
                                input logic [31:0] expWord);
      int waitCycles = 0;
      i_cond = c; i_mode = m; i_imm = im; i_opcode = op; i_s_bit = s;
      i_rn = rn; i_rd = rd; i_operand = operand;
      i_in_valid = 1'b1;
      @(negedge i_clk);
      while (!o_in_ready && waitCycles < 50) begin
         @(negedge i_clk);
         waitCycles++;
      end
      if (!o_in_ready) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
      end else if (m != 2'b11) begin
         expQ.push_back({expAddr, expWord});
         expAddr = expAddr + 32'd4;
      end
      @(posedge i_clk);
      #1;
      i_in_valid = 1'b0;
   endtask

   task automatic startSession(input logic [31:0] base, input logic withFinish);
      i_base_addr = base;
      i_start     = 1'b1;
      i_finish    = withFinish;
      @(posedge i_clk);
      #1;
      i_start  = 1'b0;
      i_finish = 1'b0;
      expAddr  = base & ~32'h3;
   endtask

   task automatic pulseFinish();
      i_finish = 1'b1;
      @(posedge i_clk);
      #1;
      i_finish = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((expQ.size() != 0 || o_mem_we) && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 100) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", expQ.size());
      end
      @(posedge i_clk);
      #1;
   endtask

   // Wait for done and verify it pulses once with busy falling next cycle.
   task automatic waitDone(input logic toggleReady);
      int  doneSeen = 0;
      bit  prevDone = 1'b0;
      bit  finished = 1'b0;
      for (int i = 0; i < 60 && !finished; i++) begin
         @(negedge i_clk);
         if (prevDone) begin
            checkOutput("busy_after_done", {63'h0, o_busy}, 64'h0);
            checkOutput("done_one_cycle", {63'h0, o_done}, 64'h0);
            finished = 1'b1;
         end else if (o_done) begin
            doneSeen++;
            checkOutput("busy_during_done", {63'h0, o_busy}, 64'h1);
            checkOutput("queue_empty_at_done", 64'(expQ.size()), 64'h0);
            prevDone = 1'b1;
         end
         @(posedge i_clk);
         #1;
         if (toggleReady) begin
            i_mem_ready = ~i_mem_ready;
         end
      end
      checkOutput("done_pulse_count", 64'(doneSeen), 64'h1);
   endtask

   // Directed test sequence.
   initial begin
      i_rst_n = 1'b0; i_start = 1'b0; i_finish = 1'b0; i_base_addr = '0;
      i_in_valid = 1'b0; i_cond = '0; i_mode = '0; i_imm = 1'b0;
      i_opcode = '0; i_s_bit = 1'b0; i_rn = '0; i_rd = '0; i_operand = '0;
      i_mem_ready = 1'b1;

      @(negedge i_clk);
      checkOutput("reset_flags", {60'h0, o_in_ready, o_mem_we, o_busy, o_done}, 64'h0);
      checkOutput("reset_addr", {32'h0, o_mem_addr}, 64'h0);
      checkOutput("reset_wdata", {32'h0, o_mem_wdata}, 64'h0);
      checkOutput("reset_counts", {40'h0, o_word_count, o_err_count}, 64'h0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      $display("[TB] session 1: start+finish together, basic encodings");
      startSession(32'h0000_0100, 1'b1);
      @(negedge i_clk);
      checkOutput("start_wins_busy", {63'h0, o_busy}, 64'h1);
      checkOutput("start_wins_in_ready", {63'h0, o_in_ready}, 64'h1);
      @(posedge i_clk);
      #1;

      applyStimulus(4'hE, 2'b00, 1'b1, 4'b0100, 1'b1, 4'h1, 4'h2, 24'h000005, 32'hE291_2005);
      @(negedge i_clk);
      checkOutput("accept_to_we_latency", {63'h0, o_mem_we}, 64'h1);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      checkOutput("word_count_after_first", {48'h0, o_word_count}, 64'h1);
      @(posedge i_clk);
      #1;

      applyStimulus(4'hE, 2'b10, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'hFFFFFE, 32'hEAFF_FFFE);
      applyStimulus(4'hE, 2'b01, 1'b0, 4'b0000, 1'b1, 4'h0, 4'h3, 24'h000000, 32'hE490_3000);
      waitDrain();

      $display("[TB] illegal bundle between two legal ones");
      applyStimulus(4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'hABC001, 32'h0000_0001);
      applyStimulus(4'h7, 2'b11, 1'b1, 4'hF, 1'b1, 4'hF, 4'hF, 24'hFFFFFF, 32'h0);
      applyStimulus(4'h1, 2'b10, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h123456, 32'h1A12_3456);
      waitDrain();
      @(negedge i_clk);
      checkOutput("err_count_one", {56'h0, o_err_count}, 64'h1);
      @(posedge i_clk);
      #1;

      $display("[TB] back-pressure: fill FIFO with mem_ready low");
      i_mem_ready = 1'b0;
      applyStimulus(4'h0, 2'b01, 1'b1, 4'hF, 1'b0, 4'h5, 4'h6, 24'h0000FF, 32'h0685_60FF);
      applyStimulus(4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000002, 32'h0000_0002);
      applyStimulus(4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000003, 32'h0000_0003);
      applyStimulus(4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000004, 32'h0000_0004);
      i_cond = 4'h0; i_mode = 2'b00; i_imm = 1'b0; i_opcode = 4'h0; i_s_bit = 1'b0;
      i_rn = 4'h0; i_rd = 4'h0; i_operand = 24'h000005;
      i_in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checkOutput("full_in_ready", {63'h0, o_in_ready}, 64'h0);
         checkOutput("stall_we", {63'h0, o_mem_we}, 64'h1);
         checkOutput("stall_addr", {32'h0, o_mem_addr}, {32'h0, expQ[0][63:32]});
         checkOutput("stall_wdata", {32'h0, o_mem_wdata}, {32'h0, expQ[0][31:0]});
      end
      @(posedge i_clk);
      #1;
      i_mem_ready = 1'b1;
      applyStimulus(4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000005, 32'h0000_0005);
      waitDrain();

      $display("[TB] finish with three queued words, mem_ready toggling");
      i_mem_ready = 1'b0;
      applyStimulus(4'h2, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000011, 32'h2000_0011);
      applyStimulus(4'h3, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000022, 32'h3000_0022);
      applyStimulus(4'h4, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000033, 32'h4000_0033);
      pulseFinish();
      @(negedge i_clk);
      checkOutput("drain_busy", {63'h0, o_busy}, 64'h1);
      checkOutput("drain_in_ready", {63'h0, o_in_ready}, 64'h0);
      @(posedge i_clk);
      #1;
      waitDone(1'b1);
      @(negedge i_clk);
      checkOutput("session1_word_count", {48'h0, o_word_count}, 64'd13);
      checkOutput("session1_err_count", {56'h0, o_err_count}, 64'd1);
      @(posedge i_clk);
      #1;

      $display("[TB] reset with two words queued");
      i_mem_ready = 1'b0;
      startSession(32'h0000_0200, 1'b0);
      applyStimulus(4'h5, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000001, 32'h5000_0001);
      applyStimulus(4'h6, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000002, 32'h6000_0002);
      i_rst_n = 1'b0;
      #1;
      checkOutput("reset_kills_we", {63'h0, o_mem_we}, 64'h0);
      checkOutput("reset_kills_busy", {63'h0, o_busy}, 64'h0);
      checkOutput("reset_clears_addr", {32'h0, o_mem_addr}, 64'h0);
      expQ.delete();
      i_mem_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checkOutput("no_write_after_reset", {63'h0, o_mem_we}, 64'h0);
      end
      @(posedge i_clk);
      #1;

      $display("[TB] address wrap and error saturation");
      startSession(32'hFFFF_FFFC, 1'b0);
      applyStimulus(4'h8, 2'b00, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000ABC, 32'h8000_0ABC);
      applyStimulus(4'h9, 2'b10, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h000010, 32'h9A00_0010);
      waitDrain();
      for (int k = 0; k < 257; k++) begin
         applyStimulus(4'h0, 2'b11, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h0, 32'h0);
      end
      @(negedge i_clk);
      checkOutput("err_count_saturates", {56'h0, o_err_count}, 64'd255);
      checkOutput("wrap_word_count", {48'h0, o_word_count}, 64'd2);
      checkOutput("wrap_addr_next", {32'h0, o_mem_addr}, 64'h4);
      @(posedge i_clk);
      #1;
      pulseFinish();
      waitDone(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
